// File: rtl/tl_mem_master.sv
// TileLink-UL line initiator: refills are a single Get answered by a BEATS-beat AccessAckData,
// writebacks are a BEATS-beat PutFullData answered by one AccessAck.
module tl_mem_master #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BEATS     = 8,
  parameter logic [3:0]  SOURCE_ID = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [BEATS*DATA_W-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [BEATS*DATA_W-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic [2:0]              mem_a_opcode,
  output logic [2:0]              mem_a_param,
  output logic [2:0]              mem_a_size,
  output logic [3:0]              mem_a_source,
  output logic [ADDR_W-1:0]       mem_a_address,
  output logic [7:0]              mem_a_mask,
  output logic [DATA_W-1:0]       mem_a_data,
  output logic                    mem_a_valid,
  input  logic                    mem_a_ready,
  input  logic [2:0]              mem_d_opcode,
  input  logic [1:0]              mem_d_param,
  input  logic [2:0]              mem_d_size,
  input  logic [3:0]              mem_d_source,
  input  logic [1:0]              mem_d_sink,
  input  logic                    mem_d_denied,
  input  logic [DATA_W-1:0]       mem_d_data,
  input  logic                    mem_d_corrupt,
  input  logic                    mem_d_valid,
  output logic                    mem_d_ready
);

  localparam int unsigned LineW = BEATS * DATA_W;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StGetA, StGetD, StPutA, StPutD, StRsp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LineW-1:0]  wdata_q;
  logic [LineW-1:0]  rdata_q;
  logic              req_ready_q, a_valid_q, d_ready_q, rsp_valid_q, rsp_err_q;
  logic              d_fire, d_err;
  logic [2:0]        d_op_exp;
  logic              unused_in;

  always_comb begin
    d_fire   = mem_d_valid && d_ready_q;
    d_op_exp = write_q ? 3'd0 : 3'd1;
    d_err    = mem_d_denied || mem_d_corrupt || (mem_d_source != SOURCE_ID) ||
               (mem_d_size != 3'd6) || (mem_d_opcode != d_op_exp);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      a_valid_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            addr_q      <= {req_addr[ADDR_W-1:6], 6'b0};
            wdata_q     <= req_wdata;
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            a_valid_q   <= 1'b1;
            state_q     <= req_write ? StPutA : StGetA;
          end
        end
        StGetA: begin
          if (mem_a_ready) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            state_q   <= StGetD;
          end
        end
        StGetD: begin
          // Errored beats still count so the whole burst is drained.
          if (d_fire) begin
            rdata_q[cnt_q*DATA_W +: DATA_W] <= mem_d_data;
            cnt_q <= cnt_q + 1'b1;
            if (d_err) rsp_err_q <= 1'b1;
            if (cnt_q == LastBeat) begin
              cnt_q       <= '0;
              d_ready_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= StRsp;
            end
          end
        end
        StPutA: begin
          if (mem_a_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastBeat) begin
              cnt_q     <= '0;
              a_valid_q <= 1'b0;
              d_ready_q <= 1'b1;
              state_q   <= StPutD;
            end
          end
        end
        StPutD: begin
          if (d_fire) begin
            if (d_err) rsp_err_q <= 1'b1;
            d_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = rsp_err_q;
  assign mem_a_valid   = a_valid_q;
  assign mem_d_ready   = d_ready_q;
  assign mem_a_opcode  = write_q ? 3'd0 : 3'd4;
  assign mem_a_param   = 3'd0;
  assign mem_a_size    = 3'd6;
  assign mem_a_source  = SOURCE_ID;
  assign mem_a_mask    = 8'hFF;
  assign mem_a_address = addr_q;
  assign mem_a_data    = (state_q == StPutA) ? wdata_q[cnt_q*DATA_W +: DATA_W] : '0;
  assign unused_in     = ^{mem_d_param, mem_d_sink, req_addr[5:0]};

endmodule

// File: tb/tb_tl_mem_master.sv
// Bench for tl_mem_master: a behavioural TileLink memory responder with randomized
// ready/valid timing, compared against per-transaction expectations built from the line data.
module tb_tl_mem_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write;
  logic [63:0]  req_addr;
  logic [511:0] req_wdata;
  logic         rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [511:0] rsp_rdata;
  logic [2:0]   mem_a_opcode, mem_a_param, mem_a_size;
  logic [3:0]   mem_a_source;
  logic [63:0]  mem_a_address, mem_a_data;
  logic [7:0]   mem_a_mask;
  logic         mem_a_valid, mem_a_ready;
  logic [2:0]   mem_d_opcode, mem_d_size;
  logic [1:0]   mem_d_param, mem_d_sink;
  logic [3:0]   mem_d_source;
  logic         mem_d_denied, mem_d_corrupt, mem_d_valid, mem_d_ready;
  logic [63:0]  mem_d_data;

  tl_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a_opcode(mem_a_opcode), .mem_a_param(mem_a_param), .mem_a_size(mem_a_size),
    .mem_a_source(mem_a_source), .mem_a_address(mem_a_address), .mem_a_mask(mem_a_mask),
    .mem_a_data(mem_a_data), .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready),
    .mem_d_opcode(mem_d_opcode), .mem_d_param(mem_d_param), .mem_d_size(mem_d_size),
    .mem_d_source(mem_d_source), .mem_d_sink(mem_d_sink), .mem_d_denied(mem_d_denied),
    .mem_d_data(mem_d_data), .mem_d_corrupt(mem_d_corrupt), .mem_d_valid(mem_d_valid),
    .mem_d_ready(mem_d_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of the last transaction, filled in by run_txn.
  logic [63:0]  obs_a_data[$];
  logic [2:0]   obs_a_op[$];
  logic [63:0]  obs_a_addr[$];
  int           field_bad, stab_bad, stray, early, d_taken;
  bit           timeout;
  logic [511:0] obs_rdata;
  logic         obs_err, obs_write;

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = {$urandom, $urandom};
    return l;
  endfunction

  function automatic int a_beat_errors(input bit wr, input logic [63:0] addr,
                                       input logic [511:0] line);
    int bad = 0;
    for (int k = 0; k < obs_a_data.size() && k < 8; k++) begin
      if (obs_a_op[k] !== (wr ? 3'd0 : 3'd4) || obs_a_addr[k] !== {addr[63:6], 6'b0} ||
          obs_a_data[k] !== (wr ? line[k*64 +: 64] : 64'h0)) bad++;
    end
    return bad;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    mem_a_ready = 0; mem_d_valid = 0; mem_d_opcode = 0; mem_d_param = 0; mem_d_size = 0;
    mem_d_source = 0; mem_d_sink = 0; mem_d_denied = 0; mem_d_corrupt = 0; mem_d_data = 0;
  endtask

  // a_mode: 0 always ready, 1 random, 2 toggle 1-0-1. rst_at >= 0 resets when that A beat shows.
  task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [511:0] line,
                         input logic [511:0] rline, input int a_mode, input int d_gap,
                         input int err_beat, input int err_kind, input int rst_at);
    int cyc, d_pend, d_need;
    bit tog, done, prev_hold;
    logic [63:0] prev_data, prev_addr;
    logic [2:0]  prev_op;
    obs_a_data.delete(); obs_a_op.delete(); obs_a_addr.delete();
    field_bad = 0; stab_bad = 0; stray = 0; early = 0; d_taken = 0; timeout = 0;
    obs_rdata = 'x; obs_err = 1'bx; obs_write = 1'bx;
    d_pend = 0; d_need = wr ? 1 : 8; tog = 1; done = 0; prev_hold = 0;
    prev_data = '0; prev_addr = '0; prev_op = '0;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = line;
    cyc = 0;
    while (!req_ready) begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin timeout = 1; req_valid = 0; return; end
    end
    @(negedge clk);
    req_valid = 0;
    for (cyc = 0; cyc < 500 && !done; cyc++) begin
      if (mem_a_valid) begin
        if (prev_hold && (mem_a_data !== prev_data || mem_a_op_changed(prev_op) ||
                          mem_a_address !== prev_addr)) stab_bad++;
        if (mem_a_size !== 3'd6 || mem_a_mask !== 8'hFF || mem_a_param !== 3'd0 ||
            mem_a_source !== 4'd0) field_bad++;
      end
      if (rst_at >= 0 && obs_a_data.size() == rst_at && mem_a_valid) begin
        rst_n = 0; mem_a_ready = 0; mem_d_valid = 0; rsp_ready = 0;
        @(negedge clk);
        return;
      end
      case (a_mode)
        0: mem_a_ready = 1;
        1: mem_a_ready = ($urandom_range(0, 1) == 1);
        default: begin mem_a_ready = tog; tog = ~tog; end
      endcase
      if (d_pend > 0 && int'($urandom_range(0, 99)) >= d_gap) begin
        mem_d_valid = 1; mem_d_opcode = wr ? 3'd0 : 3'd1; mem_d_size = 3'd6;
        mem_d_source = 4'd0; mem_d_denied = 0; mem_d_corrupt = 0;
        mem_d_data = wr ? 64'h0 : rline[d_taken*64 +: 64];
        if (d_taken == err_beat) begin
          case (err_kind)
            0: mem_d_denied = 1;
            1: mem_d_corrupt = 1;
            2: mem_d_source = 4'd5;
            3: mem_d_size = 3'd3;
            default: mem_d_opcode = wr ? 3'd1 : 3'd0;
          endcase
        end
      end else if (d_pend == 0 && $urandom_range(0, 9) < 3) begin
        // Unsolicited beat: must never be consumed.
        mem_d_valid = 1; mem_d_opcode = 3'd1; mem_d_size = 3'd6; mem_d_source = 4'd0;
        mem_d_denied = 1; mem_d_corrupt = 0; mem_d_data = {$urandom, $urandom};
      end else begin
        mem_d_valid = 0;
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      prev_hold = mem_a_valid && !mem_a_ready;
      prev_data = mem_a_data; prev_addr = mem_a_address; prev_op = mem_a_opcode;
      if (mem_a_valid && mem_a_ready) begin
        obs_a_data.push_back(mem_a_data);
        obs_a_op.push_back(mem_a_opcode);
        obs_a_addr.push_back(mem_a_address);
        if (!wr) d_pend = 8;
        else if (obs_a_data.size() == 8) d_pend = 1;
      end
      if (mem_d_valid && mem_d_ready) begin
        if (d_pend == 0) stray++;
        else begin d_pend--; d_taken++; end
      end
      if (rsp_valid) begin
        if (d_taken < d_need) early++;
        if (rsp_ready) begin
          obs_rdata = rsp_rdata; obs_err = rsp_err; obs_write = rsp_write; done = 1;
        end
      end
      @(negedge clk);
    end
    if (!done) timeout = 1;
    rsp_ready = 0; mem_a_ready = 0; mem_d_valid = 0;
  endtask

  function automatic bit mem_a_op_changed(input logic [2:0] prev);
    return mem_a_opcode !== prev;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, mem_a_valid, mem_d_ready, rsp_valid, rsp_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=00000", {req_ready, mem_a_valid, mem_d_ready,
               rsp_valid, rsp_err});
    end
    n_tests++;
    if (rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || mem_a_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release req_ready=%b a_valid=%b exp 1/0", req_ready, mem_a_valid);
    end
  endtask

  task automatic test_refill();
    logic [511:0] rl;
    for (int k = 0; k < 8; k++) rl[k*64 +: 64] = 64'h8000 + 64'(k);
    run_txn(0, 64'h40000, '0, rl, 0, 0, -1, 0, -1);
    n_tests++;
    if (obs_a_data.size() != 1 || a_beat_errors(0, 64'h40000, '0) != 0) begin
      n_fail++; $display("FAIL refill_get beats=%0d exp 1 Get at 0x40000", obs_a_data.size());
    end
    n_tests++;
    if (obs_rdata[63:0] !== 64'h8000 || obs_rdata[511:448] !== 64'h8007) begin
      n_fail++; $display("FAIL refill_beats b0=%h b7=%h exp 8000/8007", obs_rdata[63:0],
                         obs_rdata[511:448]);
    end
    n_tests++;
    if (obs_rdata !== rl) begin n_fail++; $display("FAIL refill_line got=%h exp=%h", obs_rdata, rl); end
    n_tests++;
    if (obs_err !== 1'b0 || obs_write !== 1'b0) begin
      n_fail++; $display("FAIL refill_rsp err=%b write=%b exp 0/0", obs_err, obs_write);
    end
    n_tests++;
    if (field_bad + stray + early + int'(timeout) != 0) begin
      n_fail++; $display("FAIL refill_proto field=%0d stray=%0d early=%0d to=%0d exp 0",
                         field_bad, stray, early, timeout);
    end
  endtask

  task automatic test_writeback();
    logic [511:0] wl;
    for (int k = 0; k < 8; k++) wl[k*64 +: 64] = 64'hAAAA + 64'(k);
    run_txn(1, 64'h200, wl, '0, 0, 50, -1, 0, -1);
    n_tests++;
    if (obs_a_data.size() != 8) begin
      n_fail++; $display("FAIL wb_count got=%0d exp=8", obs_a_data.size());
    end
    for (int k = 0; k < obs_a_data.size() && k < 8; k++) begin
      n_tests++;
      if (obs_a_data[k] !== 64'hAAAA + 64'(k) || obs_a_op[k] !== 3'd0 ||
          obs_a_addr[k] !== 64'h200) begin
        n_fail++; $display("FAIL wb_beat%0d data=%h op=%0d addr=%h exp %h/0/200", k,
                           obs_a_data[k], obs_a_op[k], obs_a_addr[k], 64'hAAAA + 64'(k));
      end
    end
    n_tests++;
    if (early != 0 || timeout || stray != 0) begin
      n_fail++; $display("FAIL wb_ack early=%0d to=%0d stray=%0d exp 0", early, timeout, stray);
    end
    n_tests++;
    if (obs_err !== 1'b0 || obs_write !== 1'b1) begin
      n_fail++; $display("FAIL wb_rsp err=%b write=%b exp 0/1", obs_err, obs_write);
    end
  endtask

  task automatic test_unaligned();
    logic [511:0] rl = rand_line();
    run_txn(0, 64'h23F, '0, rl, 1, 40, -1, 0, -1);
    n_tests++;
    if (obs_a_data.size() != 1 || obs_a_addr[0] !== 64'h200) begin
      n_fail++; $display("FAIL unaligned_addr beats=%0d exp 1 Get at 0x200", obs_a_data.size());
    end
    n_tests++;
    if (obs_rdata !== rl) begin n_fail++; $display("FAIL unaligned_data got=%h exp=%h", obs_rdata, rl); end
  endtask

  task automatic test_a_toggle();
    logic [511:0] wl = rand_line();
    logic [63:0]  ad = {$urandom, $urandom};
    run_txn(1, ad, wl, '0, 2, 0, -1, 0, -1);
    n_tests++;
    if (obs_a_data.size() != 8 || a_beat_errors(1, ad, wl) != 0) begin
      n_fail++; $display("FAIL toggle_beats count=%0d bad=%0d exp 8/0", obs_a_data.size(),
                         a_beat_errors(1, ad, wl));
    end
    n_tests++;
    if (stab_bad != 0) begin n_fail++; $display("FAIL toggle_stable got=%0d exp=0", stab_bad); end
  endtask

  task automatic test_denied();
    logic [511:0] rl = rand_line();
    run_txn(0, 64'h1000, '0, rl, 0, 20, 3, 0, -1);
    n_tests++;
    if (d_taken != 8 || obs_rdata !== rl) begin
      n_fail++; $display("FAIL denied_drain taken=%0d exp=8", d_taken);
    end
    n_tests++;
    if (obs_err !== 1'b1) begin n_fail++; $display("FAIL denied_err got=%b exp=1", obs_err); end
    rl = rand_line();
    run_txn(0, 64'h2000, '0, rl, 0, 0, -1, 0, -1);
    n_tests++;
    if (obs_err !== 1'b0 || obs_rdata !== rl) begin
      n_fail++; $display("FAIL denied_next err=%b exp=0", obs_err);
    end
  endtask

  task automatic test_err_kinds();
    for (int kind = 1; kind <= 4; kind++) begin
      for (int w = 0; w < 2; w++) begin
        logic [511:0] l = rand_line();
        run_txn(w == 1, {$urandom, $urandom}, l, l, 0, 0, (w == 1) ? 0 : 7, kind, -1);
        n_tests++;
        if (obs_err !== 1'b1 || timeout) begin
          n_fail++; $display("FAIL err_kind%0d_wr%0d err=%b to=%0d exp 1", kind, w, obs_err, timeout);
        end
      end
    end
  endtask

  task automatic test_reset_mid_put();
    logic [511:0] wl = rand_line();
    logic [63:0]  ad = 64'h7700;
    run_txn(1, ad, wl, '0, 0, 0, -1, 0, 4);
    n_tests++;
    if ({req_ready, mem_a_valid, mem_d_ready, rsp_valid, rsp_err} !== 5'b0 || rsp_rdata !== '0) begin
      n_fail++; $display("FAIL midput_reset ctrl=%b rdata_zero=%0d exp 00000/1", {req_ready,
                         mem_a_valid, mem_d_ready, rsp_valid, rsp_err}, rsp_rdata == '0);
    end
    rst_n = 1;
    @(negedge clk);
    wl = rand_line();
    run_txn(1, ad, wl, '0, 1, 30, -1, 0, -1);
    n_tests++;
    if (obs_a_data.size() != 8 || a_beat_errors(1, ad, wl) != 0 || obs_err !== 1'b0 || timeout) begin
      n_fail++; $display("FAIL midput_resume count=%0d bad=%0d err=%b exp 8/0/0",
                         obs_a_data.size(), a_beat_errors(1, ad, wl), obs_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 16; t++) begin
      bit           wr   = ($urandom_range(0, 1) == 1);
      logic [63:0]  ad   = {$urandom, $urandom};
      logic [511:0] l    = rand_line();
      int           eb   = ($urandom_range(0, 3) == 0) ? (wr ? 0 : int'($urandom_range(0, 7))) : -1;
      run_txn(wr, ad, l, l, int'($urandom_range(0, 2)), int'($urandom_range(0, 60)), eb,
              int'($urandom_range(0, 4)), -1);
      n_tests++;
      if (obs_a_data.size() != (wr ? 8 : 1) || a_beat_errors(wr, ad, l) != 0) begin
        n_fail++; $display("FAIL b2b%0d_a count=%0d bad=%0d", t, obs_a_data.size(),
                           a_beat_errors(wr, ad, l));
      end
      n_tests++;
      if ((!wr && obs_rdata !== l) || obs_err !== (eb >= 0) || obs_write !== wr) begin
        n_fail++; $display("FAIL b2b%0d_rsp err=%b exp=%0d write=%b exp=%0d", t, obs_err,
                           eb >= 0, obs_write, wr);
      end
      n_tests++;
      if (field_bad + stab_bad + stray + early + int'(timeout) != 0) begin
        n_fail++; $display("FAIL b2b%0d_proto field=%0d stab=%0d stray=%0d early=%0d to=%0d", t,
                           field_bad, stab_bad, stray, early, timeout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_unaligned();
    test_a_toggle();
    test_denied();
    test_err_kinds();
    test_reset_mid_put();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
